// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        FIXUP  = 2'd2,
        DONE   = 2'd3
    } div_state_t;

    // Quotient reported on divide-by-zero; sliced down to the instance width.
    localparam int MAX_WIDTH = 128;
    localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = '1;

    // Iteration counter width: counts WIDTH-1 down to 0.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// (WIDTH+1)-bit trial subtractor: minuend + ~subtrahend + 1, carry-out = no borrow.
module div_sub_stage #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] difference,
    output logic           no_borrow
);

    logic [WIDTH:0]   sub_inv;
    logic [WIDTH+1:0] sum;

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_inv
            assign sub_inv[gi] = ~subtrahend[gi];
        end
    endgenerate

    assign sum        = {1'b0, minuend} + {1'b0, sub_inv} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign difference = sum[WIDTH:0];
    assign no_borrow  = sum[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle,
// with a start/busy/resultValid handshake for the execute stage.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] registerA,
    input  logic [WIDTH-1:0] registerB,
    output logic             busy,
    output logic             resultValid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);

    localparam int CW = cnt_width(WIDTH);

    div_state_t       state_reg, state_next;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] dividend_reg;
    logic [WIDTH-1:0] dividend_raw_reg;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH:0]   part_rem_reg;
    logic             neg_q_reg;
    logic             neg_r_reg;
    logic             div0_reg;

    logic             sign_a, sign_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial_diff;
    logic             no_borrow;

    // Negating MIN wraps back to MIN, which reads as 2^(WIDTH-1) unsigned.
    assign sign_a = signedOp & registerA[WIDTH-1];
    assign sign_b = signedOp & registerB[WIDTH-1];
    assign mag_a  = sign_a ? -registerA : registerA;
    assign mag_b  = sign_b ? -registerB : registerB;

    assign shifted = (part_rem_reg << 1) | {{WIDTH{1'b0}}, dividend_reg[WIDTH-1]};

    div_sub_stage #(.WIDTH(WIDTH)) u_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, divisor_reg}),
        .difference (trial_diff),
        .no_borrow  (no_borrow)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        busy        = 1'b0;
        resultValid = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (registerB == '0) ? FIXUP : DIVIDE;
                end
            end
            DIVIDE: begin
                busy = 1'b1;
                if (count_reg == '0) begin
                    state_next = FIXUP;
                end
            end
            FIXUP: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                busy        = 1'b1;
                resultValid = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Quotient bits accumulate in dividend_reg as the dividend shifts out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg        <= '0;
            dividend_reg     <= '0;
            dividend_raw_reg <= '0;
            divisor_reg      <= '0;
            part_rem_reg     <= '0;
            neg_q_reg        <= 1'b0;
            neg_r_reg        <= 1'b0;
            div0_reg         <= 1'b0;
            quotient         <= '0;
            remainder        <= '0;
            divByZero        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        dividend_raw_reg <= registerA;
                        dividend_reg     <= mag_a;
                        divisor_reg      <= mag_b;
                        part_rem_reg     <= '0;
                        count_reg        <= CW'(WIDTH - 1);
                        neg_q_reg        <= sign_a ^ sign_b;
                        neg_r_reg        <= sign_a;
                        div0_reg         <= (registerB == '0);
                    end
                end
                DIVIDE: begin
                    part_rem_reg <= no_borrow ? trial_diff : shifted;
                    dividend_reg <= {dividend_reg[WIDTH-2:0], no_borrow};
                    count_reg    <= count_reg - CW'(1);
                end
                FIXUP: begin
                    if (div0_reg) begin
                        quotient  <= DIV0_QUOTIENT[WIDTH-1:0];
                        remainder <= dividend_raw_reg;
                        divByZero <= 1'b1;
                    end else begin
                        quotient  <= neg_q_reg ? -dividend_reg : dividend_reg;
                        remainder <= neg_r_reg ? WIDTH'(-part_rem_reg) : WIDTH'(part_rem_reg);
                        divByZero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider (WIDTH=32): results, latency and handshake corners.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signedOp = 1'b0;
    logic [31:0] registerA = '0;
    logic [31:0] registerB = '0;
    logic        busy;
    logic        resultValid;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divByZero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .signedOp    (signedOp),
        .registerA   (registerA),
        .registerB   (registerB),
        .busy        (busy),
        .resultValid (resultValid),
        .quotient    (quotient),
        .remainder   (remainder),
        .divByZero   (divByZero)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dz;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Launch one operation; lat counts clocks from the accept edge to the
    // edge that samples resultValid. inj_n re-pulses start on that cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int inj_n,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic dz, output logic bsy, output int lat);
        @(negedge clk);
        start = 1'b1; registerA = a; registerB = b; signedOp = s;
        @(posedge clk);
        lat = -1; q = '0; r = '0; dz = 1'b0; bsy = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (n == inj_n) begin
                start = 1'b1; registerA = 32'h5; registerB = 32'h1; signedOp = ~s;
            end else begin
                start = 1'b0;
            end
            if (resultValid) begin
                lat = n; q = quotient; r = remainder; dz = divByZero; bsy = busy;
                break;
            end
        end
        $display("op A=%h B=%h s=%0d -> q=%h r=%h dz=%0d lat=%0d", a, b, s, q, r, dz, lat);
    endtask

    initial begin
        logic [31:0] q, r;
        logic        dz, bsy;
        int          lat;

        vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        1'b0, 34};
        vecs[1]  = '{32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34};
        vecs[2]  = '{32'd100,      32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2,        1'b0, 34};
        vecs[3]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'd14,       32'hFFFFFFFE, 1'b0, 34};
        vecs[4]  = '{32'h1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'h1234,     1'b1, 2};
        vecs[5]  = '{32'h1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'h1234,     1'b1, 2};
        vecs[6]  = '{32'hFFFFFF9C, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFF9C, 1'b1, 2};
        vecs[7]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 34};
        vecs[8]  = '{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0,        32'h80000000, 1'b0, 34};
        vecs[9]  = '{32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 34};
        vecs[10] = '{32'd7,        32'd100,      1'b0, 32'd0,        32'd7,        1'b0, 34};
        vecs[11] = '{32'd0,        32'd5,        1'b1, 32'd0,        32'd0,        1'b0, 34};
        vecs[12] = '{32'hDEADBEEF, 32'h10,       1'b0, 32'h0DEADBEE, 32'hF,        1'b0, 34};

        // Reset state while reset is held across clock edges
        repeat (3) @(negedge clk);
        check("reset_busy",   {31'd0, busy},        32'd0);
        check("reset_valid",  {31'd0, resultValid}, 32'd0);
        check("reset_q",      quotient,             32'd0);
        check("reset_r",      remainder,            32'd0);
        check("reset_dz",     {31'd0, divByZero},   32'd0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, q, r, dz, bsy, lat);
            check($sformatf("v%0d_q", i),   q,              vecs[i].exp_q);
            check($sformatf("v%0d_r", i),   r,              vecs[i].exp_r);
            check($sformatf("v%0d_dz", i),  {31'd0, dz},    {31'd0, vecs[i].exp_dz});
            check($sformatf("v%0d_lat", i), lat,            vecs[i].exp_lat);
            check($sformatf("v%0d_busy", i), {31'd0, bsy},  32'd1);
            @(negedge clk);
            check($sformatf("v%0d_pulse", i), {31'd0, resultValid}, 32'd0);
            check($sformatf("v%0d_idle", i),  {31'd0, busy},        32'd0);
        end

        // Outputs hold after DONE while idle
        repeat (3) @(negedge clk);
        check("hold_q", quotient,  32'h0DEADBEE);
        check("hold_r", remainder, 32'hF);

        // start while busy is ignored
        do_op(32'd1000, 32'd10, 1'b0, 5, q, r, dz, bsy, lat);
        check("ign_q",   q,   32'd100);
        check("ign_r",   r,   32'd0);
        check("ign_lat", lat, 34);

        // Back-to-back: second start in the first idle cycle after DONE
        do_op(32'd100, 32'd7, 1'b0, 0, q, r, dz, bsy, lat);
        check("b2b1_q", q, 32'd14);
        do_op(32'd1000, 32'd33, 1'b0, 0, q, r, dz, bsy, lat);
        check("b2b2_q",   q,   32'd30);
        check("b2b2_r",   r,   32'd10);
        check("b2b2_lat", lat, 34);

        // Async reset during DIVIDE cycle 10
        @(negedge clk);
        start = 1'b1; registerA = 32'd5000; registerB = 32'd3; signedOp = 1'b0;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_busy",  {31'd0, busy},        32'd0);
        check("rst_valid", {31'd0, resultValid}, 32'd0);
        check("rst_q",     quotient,             32'd0);
        check("rst_r",     remainder,            32'd0);
        check("rst_dz",    {31'd0, divByZero},   32'd0);
        @(negedge clk);
        reset = 1'b0;
        do_op(32'd5000, 32'd3, 1'b0, 0, q, r, dz, bsy, lat);
        check("post_q",   q,   32'd1666);
        check("post_r",   r,   32'd2);
        check("post_lat", lat, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
